// File: rtl/mul_res_pkg.sv
// Shared widths, state encoding and saturation limits for the multiplier result unpacker.
package mul_res_pkg;

    localparam int PROD_W        = 67;
    localparam int OUT_W         = 32;
    localparam int RES_W         = 2 * OUT_W;
    localparam int CNT_W         = 8;
    localparam int SIGN_COPY_LSB = 63;

    localparam logic [OUT_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [OUT_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        SAT  = 2'd3
    } state_e;

    // The top bits of the product must all repeat bit 63; anything else is a malformed result.
    function automatic logic sign_copies_bad(input logic [PROD_W-1:0] prod);
        logic [PROD_W-SIGN_COPY_LSB-1:0] copies;
        copies = prod[PROD_W-1:SIGN_COPY_LSB];
        return ~(&copies | ~|copies);
    endfunction

endpackage

// File: rtl/mul_res_saturate.sv
// Clips a signed 64-bit result to signed 32 bits. Only built when MUL_RES_SAT_EN is defined.
`ifdef MUL_RES_SAT_EN
module mul_res_saturate
    import mul_res_pkg::*;
(
    input  logic [RES_W-1:0] val_i,
    output logic [OUT_W-1:0] sat_o,
    output logic             clip_o
);

    // The value fits in 32 bits exactly when bits [63:31] are all copies of the sign.
    logic [RES_W-OUT_W:0] upper;

    assign upper  = val_i[RES_W-1:OUT_W-1];
    assign clip_o = ~(&upper | ~|upper);
    assign sat_o  = !clip_o        ? val_i[OUT_W-1:0] :
                    val_i[RES_W-1] ? SAT_MIN : SAT_MAX;

endmodule
`endif

// File: rtl/mul_result_unpack.sv
// Captures a finished Booth product and streams it as lo/hi 32-bit beats under valid/ready.
// Optional MUL_RES_SAT_EN adds sat_i/res_sat_o for a single saturated 32-bit beat.
module mul_result_unpack
    import mul_res_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              done_i,
    input  logic              res_ready_i,
`ifdef MUL_RES_SAT_EN
    input  logic              sat_i,
    output logic              res_sat_o,
`endif
    output logic [OUT_W-1:0]  res_data_o,
    output logic              res_valid_o,
    output logic              res_last_o,
    output logic              res_err_o,
    output logic              busy_o,
    output logic              ovr_o,
    output logic [CNT_W-1:0]  res_cnt_o
);

    state_e             state_q;
    logic               done_q;
    logic [RES_W-1:0]   hold_q;
    logic               err_q;
    logic               ovr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               cap;
    logic               beat_fire;
    logic               take_sat;

    assign cap       = done_i & ~done_q;
    assign busy_o    = (state_q != IDLE);
    assign beat_fire = res_valid_o & res_ready_i;
    assign cnt_d     = cnt_q + 1'b1;

`ifdef MUL_RES_SAT_EN
    logic [OUT_W-1:0] sat_data;
    logic             sat_clip;

    mul_res_saturate u_sat (
        .val_i  (hold_q),
        .sat_o  (sat_data),
        .clip_o (sat_clip)
    );

    assign take_sat  = sat_i;
    assign res_sat_o = (state_q == SAT) & sat_clip;
`else
    assign take_sat  = 1'b0;
`endif

    // A capture is only accepted from IDLE; one arriving while a result drains is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            hold_q  <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= done_i;
            if (cap && busy_o) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cap) begin
                        hold_q  <= prod_i[RES_W-1:0];
                        err_q   <= sign_copies_bad(prod_i);
                        state_q <= take_sat ? SAT : LO;
                    end
                end
                LO: begin
                    if (beat_fire) begin
                        state_q <= HI;
                    end
                end
                HI, SAT: begin
                    if (beat_fire) begin
                        state_q <= IDLE;
                        cnt_q   <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Beat contents are pure functions of registered state, so they hold steady while stalled.
    always_comb begin
        res_data_o = '0;
        case (state_q)
            LO:      res_data_o = hold_q[OUT_W-1:0];
            HI:      res_data_o = hold_q[RES_W-1:OUT_W];
`ifdef MUL_RES_SAT_EN
            SAT:     res_data_o = sat_data;
`endif
            default: res_data_o = '0;
        endcase
    end

    assign res_valid_o = busy_o;
    assign res_last_o  = (state_q == HI) || (state_q == SAT);
    assign res_err_o   = res_valid_o & err_q;
    assign ovr_o       = ovr_q;
    assign res_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mul_result_unpack.sv
// Directed-vector bench for mul_result_unpack; inputs change and outputs are sampled on the falling edge.
module tb_mul_result_unpack;

    logic        clk;
    logic        rst;
    logic [66:0] prod_i;
    logic        done_i;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic        res_valid_o;
    logic        res_last_o;
    logic        res_err_o;
    logic        busy_o;
    logic        ovr_o;
    logic [7:0]  res_cnt_o;
`ifdef MUL_RES_SAT_EN
    logic        sat_i;
    logic        res_sat_o;
`endif

    int checks   = 0;
    int failures = 0;

    mul_result_unpack dut (
        .clk         (clk),
        .rst         (rst),
        .prod_i      (prod_i),
        .done_i      (done_i),
        .res_ready_i (res_ready_i),
`ifdef MUL_RES_SAT_EN
        .sat_i       (sat_i),
        .res_sat_o   (res_sat_o),
`endif
        .res_data_o  (res_data_o),
        .res_valid_o (res_valid_o),
        .res_last_o  (res_last_o),
        .res_err_o   (res_err_o),
        .busy_o      (busy_o),
        .ovr_o       (ovr_o),
        .res_cnt_o   (res_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [66:0] prod, input logic done, input logic ready);
        prod_i      = prod;
        done_i      = done;
        res_ready_i = ready;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expectBeat(input string tag, input logic [31:0] data, input logic last, input logic err);
        checkOutput({tag, ".valid"}, 64'(res_valid_o), 64'd1);
        checkOutput({tag, ".data"},  64'(res_data_o),  64'(data));
        checkOutput({tag, ".last"},  64'(res_last_o),  64'(last));
        checkOutput({tag, ".err"},   64'(res_err_o),   64'(err));
    endtask

    task automatic expectIdle(input string tag, input logic [7:0] cnt, input logic ovr);
        checkOutput({tag, ".valid"}, 64'(res_valid_o), 64'd0);
        checkOutput({tag, ".busy"},  64'(busy_o),      64'd0);
        checkOutput({tag, ".cnt"},   64'(res_cnt_o),   64'(cnt));
        checkOutput({tag, ".ovr"},   64'(ovr_o),       64'(ovr));
    endtask

    initial begin
        rst = 1'b1;
`ifdef MUL_RES_SAT_EN
        sat_i = 1'b0;
`endif
        applyStimulus(67'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        tick();
        expectIdle("reset", 8'd0, 1'b0);
        checkOutput("reset.data", 64'(res_data_o), 64'd0);
        checkOutput("reset.last", 64'(res_last_o), 64'd0);
        checkOutput("reset.err",  64'(res_err_o),  64'd0);
        rst = 1'b0;

        // 172*172 = 0x7390, ready held high
        applyStimulus(67'h0_0000_0000_0000_7390, 1'b1, 1'b1);
        tick(); expectBeat("t1.lo", 32'h0000_7390, 1'b0, 1'b0);
        tick(); expectBeat("t1.hi", 32'h0000_0000, 1'b1, 1'b0);
        tick(); expectIdle("t1.end", 8'd1, 1'b0);
        done_i = 1'b0;

        // -1 * 1: all ones, sign copies consistent
        tick();
        applyStimulus(67'h7_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        tick(); expectBeat("t2.lo", 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick(); expectBeat("t2.hi", 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick(); expectIdle("t2.end", 8'd2, 1'b0);
        done_i = 1'b0;

        // Consumer stalls: lo beat must not move
        tick();
        applyStimulus(67'h0_1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        tick(); expectBeat("t3.lo0", 32'h9ABC_DEF0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(); expectBeat("t3.stall", 32'h9ABC_DEF0, 1'b0, 1'b0);
        end
        res_ready_i = 1'b1;
        tick(); expectBeat("t3.hi", 32'h1234_5678, 1'b1, 1'b0);
        tick(); expectIdle("t3.end", 8'd3, 1'b0);
        done_i = 1'b0;

        // Sign copies [66:63] = 0100 flag an error, then a clean result clears it
        tick();
        applyStimulus(67'h2_0000_0000_0000_0005, 1'b1, 1'b1);
        tick(); expectBeat("t4.lo", 32'h0000_0005, 1'b0, 1'b1);
        tick(); expectBeat("t4.hi", 32'h0000_0000, 1'b1, 1'b1);
        tick(); expectIdle("t4.end", 8'd4, 1'b0);
        done_i = 1'b0;
        tick();
        applyStimulus(67'h0_0000_0001_0000_0002, 1'b1, 1'b1);
        tick(); expectBeat("t4c.lo", 32'h0000_0002, 1'b0, 1'b0);
        tick(); expectBeat("t4c.hi", 32'h0000_0001, 1'b1, 1'b0);
        tick(); expectIdle("t4c.end", 8'd5, 1'b0);
        done_i = 1'b0;

        // New completion edge while still in LO: dropped, ovr sticky
        tick();
        applyStimulus(67'h0_0000_00AA_0000_00BB, 1'b1, 1'b0);
        tick(); expectBeat("t5.lo", 32'h0000_00BB, 1'b0, 1'b0);
        done_i = 1'b0;
        tick(); checkOutput("t5.ovr_pre", 64'(ovr_o), 64'd0);
        applyStimulus(67'h0_0000_1111_0000_2222, 1'b1, 1'b0);
        tick(); expectBeat("t5.lo_kept", 32'h0000_00BB, 1'b0, 1'b0);
        checkOutput("t5.ovr", 64'(ovr_o), 64'd1);
        res_ready_i = 1'b1;
        tick(); expectBeat("t5.hi", 32'h0000_00AA, 1'b1, 1'b0);
        tick(); expectIdle("t5.end", 8'd6, 1'b1);
        tick(); expectIdle("t5.level", 8'd6, 1'b1);
        done_i = 1'b0;

        // Reset while in HI abandons the result and clears ovr/count
        tick();
        applyStimulus(67'h0_0000_0033_0000_0044, 1'b1, 1'b1);
        tick(); expectBeat("t6.lo", 32'h0000_0044, 1'b0, 1'b0);
        tick(); expectBeat("t6.hi", 32'h0000_0033, 1'b1, 1'b0);
        rst    = 1'b1;
        done_i = 1'b0;
        tick(); expectIdle("t6.rst", 8'd0, 1'b0);
        rst = 1'b0;
        tick(); expectIdle("t6.after", 8'd0, 1'b0);

        // Completion edge coinciding with the HI handshake is treated as busy
        applyStimulus(67'h0_0000_0007_0000_0008, 1'b1, 1'b1);
        tick(); expectBeat("t7.lo", 32'h0000_0008, 1'b0, 1'b0);
        done_i = 1'b0;
        tick(); expectBeat("t7.hi", 32'h0000_0007, 1'b1, 1'b0);
        applyStimulus(67'h0_0000_0009_0000_0009, 1'b1, 1'b1);
        tick(); expectIdle("t7.end", 8'd1, 1'b1);
        tick(); expectIdle("t7.drop", 8'd1, 1'b1);
        done_i = 1'b0;

`ifdef MUL_RES_SAT_EN
        // 2^32 saturates to 0x7FFFFFFF in a single beat
        tick();
        sat_i = 1'b1;
        applyStimulus(67'h0_0000_0001_0000_0000, 1'b1, 1'b1);
        tick(); expectBeat("t8.sat", 32'h7FFF_FFFF, 1'b1, 1'b0);
        checkOutput("t8.clip", 64'(res_sat_o), 64'd1);
        tick(); expectIdle("t8.end", 8'd2, 1'b1);
        sat_i  = 1'b0;
        done_i = 1'b0;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
